// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the iterative forward cipher.
// Optional macro AES_ROUND_TRACE_EN (used by aes_cipher_core) exposes the round counter.
package aes_pkg;

  localparam int unsigned NB     = 4;
  localparam int unsigned MAX_NR = 14;
  localparam int unsigned KS_W   = 32 * NB * (MAX_NR + 1);

  // Entry 0x00 is the most significant byte, so lookups index from the top.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8'hff - x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // Unsupported key lengths fall back to AES-128.
  function automatic logic [3:0] nr_of(input logic [7:0] nk);
    case (nk)
      8'd6:    return 4'd12;
      8'd8:    return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns unless final, AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] stateIn,
  input  logic [127:0] roundKey,
  input  logic         isFinal,
  output logic [127:0] stateOut
);

  function automatic logic [31:0] mixColumn(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3,
            a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3,
            a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3),
            gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3)};
  endfunction

  logic [127:0] shifted;
  logic [127:0] mixed;

  always_comb begin
    shifted = '0;
    for (int k = 0; k < 16; k++) begin
      // Row k%4 rotates left by its row number: take column (k/4 + k%4)%4 of the same row.
      shifted[127-8*k -: 8] = sbox(stateIn[127-8*(k%4 + 4*((k/4 + k%4) % 4)) -: 8]);
    end
  end

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mixColumn(shifted[127-32*c -: 32]);
    end
  end

  assign stateOut = (isFinal ? shifted : mixed) ^ roundKey;

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128/192/256 forward cipher, one round per clock, started by releasing reset.
// Define AES_ROUND_TRACE_EN to expose the round counter on roundIdx for debug tracing.
module aes_cipher_core
  import aes_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      Nk,
  input  logic [127:0]    plainText,
  input  logic [KS_W-1:0] keySchedule,
  output logic [127:0]    cipherText,
  output logic            done
`ifdef AES_ROUND_TRACE_EN
  ,
  output logic [3:0]      roundIdx
`endif
);

  logic [127:0] stateQ;
  logic [127:0] roundOut;
  logic [127:0] roundKey;
  logic [3:0]   roundQ;
  logic [3:0]   nrQ;
  logic [3:0]   rkIdx;
  logic [MAX_NR:0][127:0] rkArr;

  // Round key 0 sits in the most significant 128 bits of the schedule.
  assign rkArr = keySchedule;
  assign rkIdx = 4'(MAX_NR) - roundQ;

  always_comb begin
    roundKey = '0;
    if (roundQ <= 4'(MAX_NR)) begin
      roundKey = rkArr[rkIdx];
    end
  end

  aes_round uRound (
    .stateIn (stateQ),
    .roundKey(roundKey),
    .isFinal (roundQ == nrQ),
    .stateOut(roundOut)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ     <= '0;
      roundQ     <= '0;
      nrQ        <= '0;
      cipherText <= '0;
      done       <= 1'b0;
    end else if (roundQ == 4'd0) begin
      stateQ <= plainText ^ roundKey;
      nrQ    <= nr_of(Nk);
      roundQ <= 4'd1;
    end else if (!done) begin
      stateQ <= roundOut;
      roundQ <= roundQ + 4'd1;
      if (roundQ == nrQ) begin
        cipherText <= roundOut;
        done       <= 1'b1;
      end
    end
  end

`ifdef AES_ROUND_TRACE_EN
  assign roundIdx = roundQ;
`endif

endmodule

// File: tb/tb_aes_cipher_core.sv
// Self-checking bench for aes_cipher_core: FIPS-197 vectors, reset/abort/hold sequences,
// and random blocks against a byte-matrix AES model with an arithmetically derived S-box.
module tb_aes_cipher_core;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [7:0]     Nk = 8'd4;
  logic [127:0]   plainText = '0;
  logic [1919:0]  keySchedule = '0;
  logic [127:0]   cipherText;
  logic           done;
`ifdef AES_ROUND_TRACE_EN
  logic [3:0]     roundIdx;
`endif

  always #5 clk = ~clk;

  aes_cipher_core dut (
    .clk        (clk),
    .reset      (reset),
    .Nk         (Nk),
    .plainText  (plainText),
    .keySchedule(keySchedule),
    .cipherText (cipherText),
    .done       (done)
`ifdef AES_ROUND_TRACE_EN
    ,
    .roundIdx   (roundIdx)
`endif
  );

  int nPass = 0;
  int nChecks = 0;
  logic [7:0] sboxT [256];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic int effNk(input int nk);
    return (nk == 6 || nk == 8) ? nk : 4;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sboxT[w[31:24]], sboxT[w[23:16]], sboxT[w[15:8]], sboxT[w[7:0]]};
  endfunction

  // Unused tail words are randomised so the DUT must not depend on them.
  function automatic logic [1919:0] buildSchedule(input logic [255:0] key, input int nkIn);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1919:0] ks;
    int nk, nr;
    nk = effNk(nkIn);
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else if (i < 4 * (nr + 1)) begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = subWord(t);
        end
        w[i] = w[i-nk] ^ t;
      end else begin
        w[i] = $urandom;
      end
    end
    for (int i = 0; i < 60; i++) ks[1919-32*i -: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [127:0] encModel(input logic [127:0] pt, input logic [1919:0] ks,
                                            input int nkIn);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] coef [4];
    logic [7:0] acc;
    logic [127:0] res;
    int nr;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    nr = effNk(nkIn) + 6;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = pt[127-8*(r+4*c) -: 8];
    for (int rnd = 0; rnd <= nr; rnd++) begin
      if (rnd > 0) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) t[r][c] = sboxT[s[r][(c+r)%4]];
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            if (rnd < nr) begin
              acc = 8'h00;
              for (int j = 0; j < 4; j++) acc ^= gmul(coef[(j-r+4)%4], t[j][c]);
              s[r][c] = acc;
            end else begin
              s[r][c] = t[r][c];
            end
          end
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] ^= ks[1919-32*(4*rnd+c)-8*r -: 8];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) res[127-8*(r+4*c) -: 8] = s[r][c];
    return res;
  endfunction

  task automatic startRun(input logic [7:0] nk, input logic [127:0] pt,
                          input logic [1919:0] ks);
    @(negedge clk);
    reset = 1'b0;
    Nk = nk;
    plainText = pt;
    keySchedule = ks;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Counts edges since release (starting from startEdges) until done, bounded.
  task automatic waitDone(input int startEdges, output int edges);
    edges = startEdges;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!done && edges < 40);
  endtask

  typedef struct {
    logic [7:0]   nk;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat;
  } vec_t;

  initial begin
    vec_t vecs [4];
    logic [1919:0] ks;
    logic [127:0] exp, savedCt;
    logic [255:0] key;
    logic [7:0] nk, inv;
    int edges;
    logic [7:0] nkChoices [6];

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sboxT[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

    vecs[0] = '{8'd4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 11};
    vecs[1] = '{8'd6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 13};
    vecs[2] = '{8'd8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 15};
    vecs[3] = '{8'd5, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 11};

    // Reset state from power-up.
    repeat (2) @(posedge clk);
    #1;
    check("reset ct", cipherText, '0);
    check("reset done", 128'(done), 128'd0);

    foreach (vecs[i]) begin
      ks = buildSchedule(vecs[i].key, int'(vecs[i].nk));
      startRun(vecs[i].nk, vecs[i].pt, ks);
      waitDone(0, edges);
      check($sformatf("vec%0d ct", i), cipherText, vecs[i].ct);
      check($sformatf("vec%0d latency", i), 128'(edges), 128'(vecs[i].lat));
    end

    // Reset after completion clears the outputs.
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset after done ct", cipherText, '0);
    check("reset after done done", 128'(done), 128'd0);
`ifdef AES_ROUND_TRACE_EN
    check("reset roundIdx", 128'(roundIdx), 128'd0);
`endif

    // Abort an AES-128 run at edge 5, then re-release.
    ks = buildSchedule(vecs[0].key, 4);
    startRun(8'd4, vecs[0].pt, ks);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort ct", cipherText, '0);
    check("abort done", 128'(done), 128'd0);
    @(negedge clk);
    reset = 1'b1;
    waitDone(0, edges);
    check("rerun ct", cipherText, vecs[0].ct);
    check("rerun latency", 128'(edges), 128'd11);

    // Hold for 20 edges past done while the inputs wander.
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      plainText = {$urandom, $urandom, $urandom, $urandom};
      Nk = 8'd8;
      @(posedge clk);
      #1;
      check("hold ct", cipherText, vecs[0].ct);
      check("hold done", 128'(done), 128'd1);
    end
`ifdef AES_ROUND_TRACE_EN
    check("done roundIdx", 128'(roundIdx), 128'd11);
`endif

    // Inputs changed after edge 1 of an AES-256 run must not matter.
    ks = buildSchedule(vecs[2].key, 8);
    startRun(8'd8, vecs[2].pt, ks);
    @(posedge clk);
    #1;
    plainText = {$urandom, $urandom, $urandom, $urandom};
    Nk = 8'd4;
    waitDone(1, edges);
    check("midrun ct", cipherText, vecs[2].ct);
    check("midrun latency", 128'(edges), 128'd15);
    savedCt = cipherText;
    check("midrun stable", savedCt, vecs[2].ct);

    nkChoices = '{8'd4, 8'd6, 8'd8, 8'd5, 8'd0, 8'd7};
    for (int n = 0; n < 24; n++) begin
      nk = (n % 4 == 3) ? 8'($urandom) : nkChoices[$urandom_range(5, 0)];
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ks = buildSchedule(key, int'(nk));
      exp = {$urandom, $urandom, $urandom, $urandom};
      startRun(nk, exp, ks);
      exp = encModel(exp, ks, int'(nk));
      waitDone(0, edges);
      check($sformatf("rand%0d nk=%0d ct", n, nk), cipherText, exp);
      check($sformatf("rand%0d nk=%0d latency", n, nk), 128'(edges),
            128'(effNk(int'(nk)) + 7));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
